// File: rtl/ghost_pkg.sv
// ghost_pkg: shared direction, mode, corner and FSM definitions for the ghost move scheduler.
package ghost_pkg;
    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic MODE_SCATTER = 1'b0;
    localparam logic MODE_CHASE   = 1'b1;
    // Corner i is element i: (0,0), (639,0), (0,479), (639,479)
    localparam logic [3:0][10:0] CORNER_X = {11'd639, 11'd0, 11'd639, 11'd0};
    localparam logic [3:0][9:0]  CORNER_Y = {10'd479, 10'd479, 10'd0, 10'd0};
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_CAPTURE, ST_DONE} state_e;
    function automatic logic is_onehot(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction
endpackage

// File: rtl/ghost_mode_timer.sv
// ghost_mode_timer: counts accepted ticks and toggles between scatter and chase periods.
module ghost_mode_timer #(
    parameter int SCATTER_TICKS = 70,
    parameter int CHASE_TICKS   = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_en_i,
    input  logic clear_i,
    output logic mode_o,
    output logic mode_changed_o
);
    localparam int CW = $clog2((SCATTER_TICKS > CHASE_TICKS ? SCATTER_TICKS : CHASE_TICKS) + 1);
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic mode_q, mode_d, mc_q, mc_d, hit;
    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        hit     = tick_en_i && (cnt_inc == (mode_q ? CW'(CHASE_TICKS) : CW'(SCATTER_TICKS)));
        cnt_d   = hit ? '0 : (tick_en_i ? cnt_inc : cnt_q);
        mode_d  = hit ? ~mode_q : mode_q;
        mc_d    = hit ? 1'b1 : (clear_i ? 1'b0 : mc_q);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= 1'b0;
            mc_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            mc_q   <= mc_d;
        end
    end
    assign mode_o         = mode_q;
    assign mode_changed_o = mc_q;
endmodule

// File: rtl/ghost_move_scheduler.sv
// ghost_move_scheduler: time-shares one ghost_control unit across NUM_GHOSTS ghosts per game tick
// and commits each returned direction into a per-ghost register.
module ghost_move_scheduler import ghost_pkg::*; #(
    parameter int         NUM_GHOSTS    = 4,
    parameter int         CTRL_LAT      = 3,
    parameter int         SCATTER_TICKS = 70,
    parameter int         CHASE_TICKS   = 200,
    parameter logic [3:0] INIT_DIR      = DIR_LEFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic [10:0]              pacman_x,
    input  logic [9:0]               pacman_y,
    input  logic [11*NUM_GHOSTS-1:0] ghost_x_flat,
    input  logic [10*NUM_GHOSTS-1:0] ghost_y_flat,
    output logic [10:0]              gc_ghost_x,
    output logic [9:0]               gc_ghost_y,
    output logic [10:0]              gc_target_x,
    output logic [9:0]               gc_target_y,
    output logic [3:0]               gc_prev_dir,
    input  logic [3:0]               gc_move_dir,
    output logic [4*NUM_GHOSTS-1:0]  ghost_dir_flat,
    output logic                     dir_valid,
    output logic                     busy,
    output logic                     mode,
    output logic                     overrun
);
    localparam int IW = NUM_GHOSTS > 1 ? $clog2(NUM_GHOSTS) : 1;
    localparam int WW = CTRL_LAT > 1 ? $clog2(CTRL_LAT) : 1;
    state_e st_q, st_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [10:0] pac_x_q, gc_x_q, gc_tx_q;
    logic [9:0]  pac_y_q, gc_y_q, gc_ty_q;
    logic [3:0]  gc_pd_q;
    logic [11*NUM_GHOSTS-1:0] snap_x_q;
    logic [10*NUM_GHOSTS-1:0] snap_y_q;
    logic [4*NUM_GHOSTS-1:0]  dir_q;
    logic ovr_q, accept, mode_changed;
    logic [1:0] cidx;
    assign accept = (st_q == ST_IDLE) && tick;
    assign cidx   = 2'(idx_q);
    ghost_mode_timer #(.SCATTER_TICKS(SCATTER_TICKS), .CHASE_TICKS(CHASE_TICKS)) u_timer (
        .clk(clk), .rst_n(rst_n), .tick_en_i(accept), .clear_i(st_q == ST_DONE),
        .mode_o(mode), .mode_changed_o(mode_changed)
    );
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        wcnt_d = wcnt_q;
        unique case (st_q)
            ST_IDLE: begin
                st_d  = tick ? ST_LOAD : ST_IDLE;
                idx_d = '0;
            end
            ST_LOAD: begin
                st_d   = ST_WAIT;
                wcnt_d = WW'(CTRL_LAT - 1);
            end
            ST_WAIT: begin
                st_d   = (wcnt_q == '0) ? ST_CAPTURE : ST_WAIT;
                wcnt_d = (wcnt_q == '0) ? wcnt_q : wcnt_q - 1'b1;
            end
            ST_CAPTURE: begin
                st_d  = (idx_q == IW'(NUM_GHOSTS - 1)) ? ST_DONE : ST_LOAD;
                idx_d = (idx_q == IW'(NUM_GHOSTS - 1)) ? idx_q : idx_q + 1'b1;
            end
            default: st_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            idx_q    <= '0;
            wcnt_q   <= '0;
            pac_x_q  <= '0;
            pac_y_q  <= '0;
            snap_x_q <= '0;
            snap_y_q <= '0;
            gc_x_q   <= '0;
            gc_y_q   <= '0;
            gc_tx_q  <= '0;
            gc_ty_q  <= '0;
            gc_pd_q  <= '0;
            dir_q    <= {NUM_GHOSTS{INIT_DIR}};
            ovr_q    <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            wcnt_q <= wcnt_d;
            if (accept) begin
                pac_x_q  <= pacman_x;
                pac_y_q  <= pacman_y;
                snap_x_q <= ghost_x_flat;
                snap_y_q <= ghost_y_flat;
            end
            if (st_q == ST_LOAD) begin
                gc_x_q  <= snap_x_q[11*idx_q +: 11];
                gc_y_q  <= snap_y_q[10*idx_q +: 10];
                gc_tx_q <= mode ? pac_x_q : CORNER_X[cidx];
                gc_ty_q <= mode ? pac_y_q : CORNER_Y[cidx];
                // A cleared previous direction lets the ghost reverse on a mode change
                gc_pd_q <= mode_changed ? DIR_NONE : dir_q[4*idx_q +: 4];
            end
            if (st_q == ST_CAPTURE && is_onehot(gc_move_dir))
                dir_q[4*idx_q +: 4] <= gc_move_dir;
            if (tick && st_q != ST_IDLE)
                ovr_q <= 1'b1;
        end
    end
    assign gc_ghost_x     = gc_x_q;
    assign gc_ghost_y     = gc_y_q;
    assign gc_target_x    = gc_tx_q;
    assign gc_target_y    = gc_ty_q;
    assign gc_prev_dir    = gc_pd_q;
    assign ghost_dir_flat = dir_q;
    assign dir_valid      = st_q == ST_DONE;
    assign busy           = st_q == ST_LOAD || st_q == ST_WAIT || st_q == ST_CAPTURE;
    assign overrun        = ovr_q;
endmodule

// File: tb/tb_ghost_move_scheduler.sv
// tb_ghost_move_scheduler: scoreboard bench with a scripted 3-cycle shared unit and a sweep-level reference model.
module tb_ghost_move_scheduler;
    localparam int N = 4;
    logic clk = 0, rst_n = 0, tick = 0;
    logic [10:0] pacman_x = 0;
    logic [9:0]  pacman_y = 0;
    logic [11*N-1:0] gx_flat = 0;
    logic [10*N-1:0] gy_flat = 0;
    logic [10:0] gc_ghost_x, gc_target_x;
    logic [9:0]  gc_ghost_y, gc_target_y;
    logic [3:0]  gc_prev_dir, gc_move_dir;
    logic [4*N-1:0] ghost_dir_flat;
    logic dir_valid, busy, mode, overrun;
    always #5 clk = ~clk;
    ghost_move_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .pacman_x(pacman_x), .pacman_y(pacman_y),
        .ghost_x_flat(gx_flat), .ghost_y_flat(gy_flat), .gc_ghost_x(gc_ghost_x), .gc_ghost_y(gc_ghost_y),
        .gc_target_x(gc_target_x), .gc_target_y(gc_target_y), .gc_prev_dir(gc_prev_dir),
        .gc_move_dir(gc_move_dir), .ghost_dir_flat(ghost_dir_flat), .dir_valid(dir_valid),
        .busy(busy), .mode(mode), .overrun(overrun)
    );
    // Shared unit stand-in: the answer is scripted by ghost x[2:0] (0..3 one-hot, 4 none, else invalid)
    function automatic logic [3:0] resp(input logic [10:0] x);
        int c = int'(x[2:0]);
        return c < 4 ? 4'(1 << c) : (c == 4 ? 4'b0000 : 4'b0101);
    endfunction
    logic [3:0] p1 = 0, p2 = 0, p3 = 0;
    always @(posedge clk) begin
        p1 <= resp(gc_ghost_x);
        p2 <= p1;
        p3 <= p2;
    end
    assign gc_move_dir = p3;
    typedef struct {logic [10:0] gx; logic [9:0] gy; logic [10:0] tx; logic [9:0] ty; logic [3:0] pd;} gc_t;
    typedef struct {logic [4*N-1:0] dirs; logic md;} sw_t;
    gc_t gq[$];
    sw_t sq[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    logic [3:0] m_dir[N];
    logic m_mode, m_mc, m_ovr;
    int m_cnt, last_acc;
    bit active;
    task automatic m_reset();
        for (int k = 0; k < N; k++) m_dir[k] = 4'b1000;
        m_mode = 0; m_mc = 0; m_ovr = 0; m_cnt = 0; active = 0; last_acc = 0;
        gq.delete();
        sq.delete();
    endtask
    // One cycle of stimulus; an accepted tick runs the whole sweep in the model at once
    task automatic step(input bit tk, input bit rnd);
        gc_t g;
        sw_t s;
        logic [3:0] r;
        @(negedge clk);
        if (rnd) begin
            pacman_x = 11'($urandom);
            pacman_y = 10'($urandom);
            for (int k = 0; k < N; k++) begin
                gx_flat[11*k +: 11] = 11'($urandom);
                gy_flat[10*k +: 10] = 10'($urandom);
            end
        end
        tick = tk;
        if (!tk) return;
        chk("overrun", overrun, m_ovr);
        if (active && cyc - last_acc < 22) begin
            m_ovr = 1;
            return;
        end
        active = 1;
        last_acc = cyc;
        m_cnt++;
        if (m_cnt == (m_mode ? 200 : 70)) begin
            m_mode = !m_mode;
            m_cnt = 0;
            m_mc = 1;
        end
        for (int k = 0; k < N; k++) begin
            g.gx = gx_flat[11*k +: 11];
            g.gy = gy_flat[10*k +: 10];
            g.tx = m_mode ? pacman_x : ((k % 2 == 1) ? 11'd639 : 11'd0);
            g.ty = m_mode ? pacman_y : ((k % 4 >= 2) ? 10'd479 : 10'd0);
            g.pd = m_mc ? 4'b0000 : m_dir[k];
            gq.push_back(g);
            r = resp(g.gx);
            if ($countones(r) == 1) m_dir[k] = r;
        end
        m_mc = 0;
        for (int k = 0; k < N; k++) s.dirs[4*k +: 4] = m_dir[k];
        s.md = m_mode;
        sq.push_back(s);
    endtask
    task automatic set_codes(input int c0, input int c1, input int c2, input int c3);
        int cs[4] = '{c0, c1, c2, c3};
        for (int k = 0; k < N; k++) begin
            gx_flat[11*k +: 11] = {8'($urandom), 3'(cs[k])};
            gy_flat[10*k +: 10] = 10'($urandom);
        end
    endtask
    task automatic chk_reset();
        chk("rst_gc_ghost_x", gc_ghost_x, 0);
        chk("rst_gc_ghost_y", gc_ghost_y, 0);
        chk("rst_gc_target_x", gc_target_x, 0);
        chk("rst_gc_target_y", gc_target_y, 0);
        chk("rst_gc_prev_dir", gc_prev_dir, 0);
        chk("rst_dirs", ghost_dir_flat, {N{4'b1000}});
        chk("rst_dir_valid", dir_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode, 0);
        chk("rst_overrun", overrun, 0);
    endtask
    // Monitor: gc_* checked mid-WAIT of each ghost slot, sweep results checked on dir_valid
    initial begin
        int r = 0;
        bit bp = 0;
        gc_t g;
        sw_t s;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bp = 0;
                continue;
            end
            r = (busy && !bp) ? 0 : r + 1;
            if (busy && r % 5 == 2 && r < 20) begin
                if (gq.size() == 0) chk("unexpected_gc_slot", 1, 0);
                else begin
                    g = gq.pop_front();
                    chk("gc_ghost_x", gc_ghost_x, g.gx);
                    chk("gc_ghost_y", gc_ghost_y, g.gy);
                    chk("gc_target_x", gc_target_x, g.tx);
                    chk("gc_target_y", gc_target_y, g.ty);
                    chk("gc_prev_dir", gc_prev_dir, g.pd);
                end
            end
            if (dir_valid) begin
                if (sq.size() == 0) chk("spurious_dir_valid", 1, 0);
                else begin
                    s = sq.pop_front();
                    chk("ghost_dir_flat", ghost_dir_flat, s.dirs);
                    chk("mode", mode, s.md);
                    chk("latency", r + 1, 21);
                    chk("busy_at_done", busy, 0);
                end
            end
            bp = busy;
        end
    end
    initial begin
        m_reset();
        repeat (3) @(negedge clk);
        chk_reset();
        @(negedge clk);
        rst_n = 1;
        pacman_x = 100;
        pacman_y = 50;
        set_codes(1, 2, 3, 0);
        step(1, 0);
        repeat (8) step(0, 0);
        pacman_x = 300;
        repeat (16) step(0, 0);
        chk("sweep1_dirs", ghost_dir_flat, 16'b0001_1000_0100_0010);
        set_codes(0, 1, 4, 2);
        step(1, 0);
        repeat (4) step(0, 0);
        step(1, 0);
        repeat (20) step(0, 0);
        chk("overrun_sticky", overrun, 1);
        chk("sweep2_dirs", ghost_dir_flat, 16'b0100_1000_0010_0001);
        step(1, 1);
        repeat (9) step(0, 1);
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_reset();
        m_reset();
        @(negedge clk);
        #2 rst_n = 1;
        repeat (320) begin
            int g = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 21)) : int'($urandom_range(22, 26));
            step(1, 1);
            repeat (g - 1) step(0, 1);
        end
        repeat (30) step(0, 1);
        chk("gc_queue_drained", gq.size(), 0);
        chk("sweep_queue_drained", sq.size(), 0);
        chk("final_mode", mode, m_mode);
        chk("final_overrun", overrun, m_ovr);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
